// File: rtl/gps_pkg.sv
// Shared GPS definitions: C/A code length, FSM state type and the PRN
// G2 tap-pair table used to form the satellite-specific code.
package gps_pkg;

  localparam int CODE_LEN = 1023;
  localparam int LFSR_W   = 10;

  typedef enum logic [1:0] {
    IDLE,
    SLEW,
    DONE
  } ca_state_e;

  // G2 output tap pair, stage numbers 1..10
  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
  } tap_pair_t;

  // Entry k holds the tap pair for PRN k+1; high nibble = a, low nibble = b
  localparam logic [7:0] PRN_TAPS [32] = '{
    8'h26, 8'h37, 8'h48, 8'h59, 8'h19, 8'h2A, 8'h18, 8'h29,
    8'h3A, 8'h23, 8'h34, 8'h56, 8'h67, 8'h78, 8'h89, 8'h9A,
    8'h14, 8'h25, 8'h36, 8'h47, 8'h58, 8'h69, 8'h13, 8'h46,
    8'h57, 8'h68, 8'h79, 8'h8A, 8'h16, 8'h27, 8'h38, 8'h49
  };

  function automatic tap_pair_t prn_taps(input logic [4:0] n_sat);
    return tap_pair_t'(PRN_TAPS[n_sat]);
  endfunction

  // Select LFSR stage 'stage' (1-based) from a register whose bit i holds stage i+1
  function automatic logic lfsr_tap(input logic [LFSR_W-1:0] s, input logic [3:0] stage);
    logic r;
    r = 1'b0;
    for (int unsigned i = 0; i < LFSR_W; i++) begin
      if (32'(stage) == i + 1) r = s[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/ca_code_gen_if.sv
// Register-bank side of the C/A code generator: control levels and strobes
// toward the generator, slew-completion pulse back.
interface ca_code_gen_if;

  logic        enable;
  logic [4:0]  n_sat;
  logic        chip_tick;
  logic        phase_start;
  logic [15:0] phase;
  logic        phase_done;

  modport master (
    output enable, n_sat, chip_tick, phase_start, phase,
    input  phase_done
  );

  modport slave (
    input  enable, n_sat, chip_tick, phase_start, phase,
    output phase_done
  );

endinterface

// File: rtl/ca_prn_lfsr.sv
// G1/G2 Gold-code LFSR pair with PRN tap selection. Reload wins over advance.
module ca_prn_lfsr
  import gps_pkg::*;
(
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       advance_in,
  input  logic       reload_in,
  input  logic [4:0] n_sat_in,
  output logic       chip_out
);

  // bit i holds stage i+1; stage 1 receives feedback
  logic [LFSR_W-1:0] g1_q, g1_d;
  logic [LFSR_W-1:0] g2_q, g2_d;
  tap_pair_t         taps;

  // next-state: reload to all ones, or shift one chip
  always_comb begin
    g1_d = g1_q;
    g2_d = g2_q;
    if (reload_in) begin
      g1_d = '1;
      g2_d = '1;
    end else if (advance_in) begin
      g1_d = {g1_q[LFSR_W-2:0], g1_q[2] ^ g1_q[9]};
      g2_d = {g2_q[LFSR_W-2:0],
              g2_q[1] ^ g2_q[2] ^ g2_q[5] ^ g2_q[7] ^ g2_q[8] ^ g2_q[9]};
    end
  end

  // LFSR state registers
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      g1_q <= '1;
      g2_q <= '1;
    end else begin
      g1_q <= g1_d;
      g2_q <= g2_d;
    end
  end

  // chip combines G1 output with the selected G2 taps; n_sat acts without reload
  always_comb begin
    taps     = prn_taps(n_sat_in);
    chip_out = g1_q[LFSR_W-1] ^ lfsr_tap(g2_q, taps.a) ^ lfsr_tap(g2_q, taps.b);
  end

endmodule

// File: rtl/ca_code_gen.sv
// GPS C/A code generator: free-running chip index on chip strobes, with a
// phase-slew FSM that reloads the code and fast-forwards to a requested chip.
module ca_code_gen #(
  parameter int CODE_LEN = gps_pkg::CODE_LEN,
  parameter int SLEW_W   = 10
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              enable_in,
  input  logic [4:0]        n_sat_in,
  input  logic              chip_tick_in,
  input  logic              ca_phase_start_in,
  input  logic [15:0]       ca_phase_in,
  output logic              code_phase_done_out,
  output logic              ca_chip_out,
  output logic              epoch_out,
  output logic [SLEW_W-1:0] chip_idx_out
);

  import gps_pkg::*;

  localparam logic [SLEW_W-1:0] IDX_LAST  = SLEW_W'(CODE_LEN - 1);
  localparam logic [15:0]       PHASE_MAX = 16'(CODE_LEN - 1);

  ca_state_e         state_q, state_d;
  logic [SLEW_W-1:0] idx_q, idx_d;
  logic [SLEW_W-1:0] cnt_q, cnt_d;
  logic              epoch_q, epoch_d;
  logic              done_q, done_d;
  logic              start_q, start_d;

  logic              start_edge;
  logic [SLEW_W-1:0] phase_clamped;
  logic              lfsr_adv;
  logic              lfsr_reload;
  logic              chip_raw;

  ca_prn_lfsr u_lfsr (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .advance_in (lfsr_adv),
    .reload_in  (lfsr_reload),
    .n_sat_in   (n_sat_in),
    .chip_out   (chip_raw)
  );

  // start edge detection and requested phase clamped to the last chip
  always_comb begin
    start_d       = ca_phase_start_in;
    start_edge    = ca_phase_start_in & ~start_q;
    phase_clamped = (ca_phase_in >= PHASE_MAX) ? IDX_LAST : ca_phase_in[SLEW_W-1:0];
  end

  // FSM next-state, index/slew counters and LFSR control
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    epoch_d     = 1'b0;
    done_d      = 1'b0;
    lfsr_adv    = 1'b0;
    lfsr_reload = 1'b0;
    if (!enable_in) begin
      state_d     = IDLE;
      idx_d       = '0;
      cnt_d       = '0;
      lfsr_reload = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          // start beats a coincident tick; the tick is dropped
          if (start_edge) begin
            lfsr_reload = 1'b1;
            idx_d       = '0;
            cnt_d       = phase_clamped;
            state_d     = SLEW;
          end else if (chip_tick_in) begin
            lfsr_adv = 1'b1;
            if (idx_q == IDX_LAST) begin
              idx_d   = '0;
              epoch_d = 1'b1;
            end else begin
              idx_d = idx_q + SLEW_W'(1);
            end
          end
        end
        SLEW: begin
          if (cnt_q == '0) begin
            state_d = DONE;
          end else begin
            lfsr_adv = 1'b1;
            idx_d    = (idx_q == IDX_LAST) ? '0 : idx_q + SLEW_W'(1);
            cnt_d    = cnt_q - SLEW_W'(1);
          end
        end
        DONE: begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // state and registered outputs
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      epoch_q <= 1'b0;
      done_q  <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      epoch_q <= epoch_d;
      done_q  <= done_d;
      start_q <= start_d;
    end
  end

  // pulses and chip are forced low at once by disable or reset
  always_comb begin
    code_phase_done_out = done_q & enable_in;
    epoch_out           = epoch_q & enable_in;
    ca_chip_out         = chip_raw & enable_in & ~rst_in;
    chip_idx_out        = idx_q;
  end

endmodule

// File: tb/tb_ca_code_gen.sv
// Self-checking bench for ca_code_gen: directed scenarios plus randomized
// traffic against a chip-index-level reference model.
module tb_ca_code_gen;

  localparam int CODE_LEN = 1023;

  logic       clk = 1'b0;
  logic       rst;
  logic       chip;
  logic       epoch;
  logic [9:0] idx;

  ca_code_gen_if bus ();

  ca_code_gen #(.CODE_LEN(CODE_LEN), .SLEW_W(10)) dut (
    .clk_in              (clk),
    .rst_in              (rst),
    .enable_in           (bus.enable),
    .n_sat_in            (bus.n_sat),
    .chip_tick_in        (bus.chip_tick),
    .ca_phase_start_in   (bus.phase_start),
    .ca_phase_in         (bus.phase),
    .code_phase_done_out (bus.phase_done),
    .ca_chip_out         (chip),
    .epoch_out           (epoch),
    .chip_idx_out        (idx)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // reference code table: ca_ref[prn-1][chip]
  bit ca_ref [32][CODE_LEN];
  int tap_a [32] = '{2,3,4,5,1,2,1,2,3,2,3,5,6,7,8,9,1,2,3,4,5,6,1,4,5,6,7,8,1,2,3,4};
  int tap_b [32] = '{6,7,8,9,9,10,8,9,10,3,4,6,7,8,9,10,4,5,6,7,8,9,3,6,7,8,9,10,6,7,8,9};

  task automatic build_table();
    bit g1 [1:10];
    bit g2 [1:10];
    bit f1, f2;
    for (int p = 0; p < 32; p++) begin
      for (int s = 1; s <= 10; s++) begin g1[s] = 1'b1; g2[s] = 1'b1; end
      for (int k = 0; k < CODE_LEN; k++) begin
        ca_ref[p][k] = g1[10] ^ g2[tap_a[p]] ^ g2[tap_b[p]];
        f1 = g1[3] ^ g1[10];
        f2 = g2[2] ^ g2[3] ^ g2[6] ^ g2[8] ^ g2[9] ^ g2[10];
        for (int s = 10; s >= 2; s--) begin g1[s] = g1[s-1]; g2[s] = g2[s-1]; end
        g1[1] = f1;
        g2[1] = f2;
      end
    end
  endtask

  // model: code position, pending slew (target chip and done cycle)
  int cyc = 0;
  int m_idx, m_target, m_end;
  bit m_busy, m_epoch, m_done, m_start_prev;
  int done_seen = 0;

  task automatic model_reset();
    m_idx = 0; m_busy = 0; m_epoch = 0; m_done = 0; m_start_prev = 0;
  endtask

  task automatic model_clock();
    bit edge_s;
    cyc++;
    edge_s = bus.phase_start && !m_start_prev;
    m_start_prev = bus.phase_start;
    m_epoch = 0;
    m_done  = 0;
    if (rst) begin
      model_reset();
    end else if (!bus.enable) begin
      m_idx = 0; m_busy = 0;
    end else if (m_busy) begin
      if (m_idx < m_target) m_idx++;
      if (cyc == m_end) begin m_done = 1; m_busy = 0; end
    end else if (edge_s) begin
      m_busy   = 1;
      m_idx    = 0;
      m_target = (int'(bus.phase) >= CODE_LEN - 1) ? CODE_LEN - 1 : int'(bus.phase);
      m_end    = cyc + m_target + 2;
    end else if (bus.chip_tick) begin
      if (m_idx == CODE_LEN - 1) begin m_idx = 0; m_epoch = 1; end
      else m_idx++;
    end
  endtask

  task automatic check_outputs();
    bit live;
    live = bus.enable && !rst;
    check_eq("chip", chip, live ? ca_ref[bus.n_sat][m_idx] : 1'b0);
    check_eq("idx", idx, m_idx);
    check_eq("epoch", epoch, live && m_epoch);
    check_eq("done", bus.phase_done, live && m_done);
  endtask

  task automatic clk_step();
    @(posedge clk);
    model_clock();
    #1;
    check_outputs();
    if (bus.phase_done) done_seen++;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    clk_step();
    rst = 1'b0;
    clk_step();
  endtask

  task automatic capture10(output logic [9:0] cap);
    bus.chip_tick = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cap[9-i] = chip;
      clk_step();
    end
    bus.chip_tick = 1'b0;
  endtask

  // start a slew and return clocks from the accepting edge to the done pulse
  task automatic run_slew(input logic [15:0] ph, output int lat);
    bus.phase_start = 1'b0;
    clk_step();
    bus.phase = ph;
    bus.phase_start = 1'b1;
    clk_step();
    bus.phase_start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 1100 && lat < 0; k++) begin
      bus.chip_tick = $urandom_range(0, 1);
      clk_step();
      if (bus.phase_done) lat = k;
    end
    bus.chip_tick = 1'b0;
  endtask

  initial begin
    logic [9:0] cap;
    int lat, epochs, d0;

    build_table();
    rst = 1'b1;
    bus.enable = 1'b0; bus.n_sat = 5'd0; bus.chip_tick = 1'b0;
    bus.phase_start = 1'b0; bus.phase = 16'd0;
    model_reset();
    #1;
    check_eq("rst_chip", chip, 0);
    check_eq("rst_idx", idx, 0);
    repeat (3) clk_step();
    bus.enable = 1'b1;
    clk_step();
    check_eq("rst_chip_en", chip, 0);
    rst = 1'b0;
    clk_step();

    // PRN 1 first chips
    capture10(cap);
    check_eq("prn1_chips", cap, 10'b1100100000);
    check_eq("prn1_idx", idx, 10);

    // PRN 2 first chips, then a full epoch
    pulse_reset();
    bus.n_sat = 5'd1;
    capture10(cap);
    check_eq("prn2_chips", cap, 10'b1110010000);
    pulse_reset();
    bus.chip_tick = 1'b1;
    epochs = 0;
    for (int i = 0; i < CODE_LEN; i++) begin
      clk_step();
      if (epoch) begin
        epochs++;
        check_eq("epoch_idx", idx, 0);
      end
    end
    check_eq("epoch_count", epochs, 1);
    capture10(cap);
    check_eq("prn2_repeat", cap, 10'b1110010000);

    // phase slews
    bus.n_sat = 5'd0;
    run_slew(16'd100, lat);
    check_eq("slew100_lat", lat, 102);
    check_eq("slew100_idx", idx, 100);
    clk_step();
    check_eq("slew100_chip", chip, ca_ref[0][100]);
    run_slew(16'd0, lat);
    check_eq("slew0_lat", lat, 2);
    check_eq("slew0_idx", idx, 0);
    run_slew(16'hFFFF, lat);
    check_eq("slewmax_lat", lat, 1024);
    check_eq("slewmax_idx", idx, 1022);
    run_slew(16'd1023, lat);
    check_eq("slew1023_idx", idx, 1022);

    // enable dropped mid-slew
    d0 = done_seen;
    bus.phase = 16'd500; bus.phase_start = 1'b1;
    clk_step();
    bus.phase_start = 1'b0;
    repeat (50) clk_step();
    bus.enable = 1'b0;
    #1;
    check_eq("dis_chip", chip, 0);
    repeat (3) clk_step();
    check_eq("dis_idx", idx, 0);
    bus.enable = 1'b1;
    repeat (600) clk_step();
    check_eq("dis_no_done", done_seen - d0, 0);

    // start held high: one slew only
    d0 = done_seen;
    bus.phase = 16'd10; bus.phase_start = 1'b1;
    repeat (5000) clk_step();
    bus.phase_start = 1'b0;
    clk_step();
    check_eq("held_one_done", done_seen - d0, 1);

    // reset mid-slew
    d0 = done_seen;
    bus.phase = 16'd300; bus.phase_start = 1'b1;
    clk_step();
    bus.phase_start = 1'b0;
    repeat (20) clk_step();
    rst = 1'b1;
    #1;
    check_eq("rstmid_idx", idx, 0);
    check_eq("rstmid_chip", chip, 0);
    check_eq("rstmid_done", bus.phase_done, 0);
    model_reset();
    repeat (2) clk_step();
    rst = 1'b0;
    repeat (400) clk_step();
    check_eq("rstmid_no_done", done_seen - d0, 0);

    // start edge with a coincident tick
    bus.chip_tick = 1'b1;
    repeat (5) clk_step();
    bus.phase = 16'd0; bus.phase_start = 1'b1;
    clk_step();
    check_eq("coinc_idx", idx, 0);
    bus.chip_tick = 1'b0; bus.phase_start = 1'b0;
    clk_step();
    clk_step();
    check_eq("coinc_done", bus.phase_done, 1);

    // randomized traffic
    for (int i = 0; i < 6000; i++) begin
      bus.chip_tick = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 40) == 0) bus.n_sat = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 60) == 0) bus.phase_start = ~bus.phase_start;
      if ($urandom_range(0, 3) == 0) bus.phase = 16'($urandom);
      else bus.phase = 16'($urandom_range(0, 1100));
      if ($urandom_range(0, 300) == 0) bus.enable = 1'b0;
      else if ($urandom_range(0, 2) == 0) bus.enable = 1'b1;
      if ($urandom_range(0, 700) == 0) begin
        pulse_reset();
      end else begin
        clk_step();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
